// File: rtl/radix_2_butterfly_pipe.sv
// Pipelined radix-2 butterfly: CT (NTT) or GS (INTT) per transaction, fully reduced mod Q.
// Build option: define BFLY_INTT_SCALE_EN to fold the 1/2 scaling into INTT outputs.
module radix_2_butterfly_pipe #(
    parameter int N      = 17,
    parameter int Q      = 65537,
    parameter int TWOINV = 32769,
    parameter int LAT    = 3        // legal 2..4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [N-1:0] an,
    input  logic [N-1:0] bn,
    input  logic [N-1:0] tf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         range_err
);

    localparam int PRE = LAT - 2;
    localparam logic [N-1:0]   QN = N'(Q);
    localparam logic [N:0]     Q1 = (N+1)'(Q);
    localparam logic [2*N-1:0] Q2 = (2*N)'(Q);
    localparam logic [N-1:0]   TW = N'(TWOINV);
`ifdef BFLY_INTT_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    function automatic logic [N-1:0] addmod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= Q1) ? N'(s - Q1) : N'(s);
    endfunction

    function automatic logic [N-1:0] submod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} + Q1 - {1'b0, y};
        return (s >= Q1) ? N'(s - Q1) : N'(s);
    endfunction

    function automatic logic [N-1:0] mulmod(input logic [N-1:0] x, input logic [N-1:0] y);
        return N'(({{N{1'b0}}, x} * {{N{1'b0}}, y}) % Q2);
    endfunction

    // Odd x: (x+Q)/2 == (x>>1) + (Q+1)/2, which stays below Q without a wide add.
    function automatic logic [N-1:0] half(input logic [N-1:0] x);
        return x[0] ? (x >> 1) + TW : (x >> 1);
    endfunction

    logic         en;
    logic         accept;
    logic [N-1:0] an_r, bn_r, tf_r;

    assign in_ready = !out_valid || out_ready;
    assign en       = in_ready;
    assign accept   = in_valid && in_ready;
    assign an_r     = an % QN;
    assign bn_r     = bn % QN;
    assign tf_r     = tf % QN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            range_err <= 1'b0;
        else if (accept && (an >= QN || bn >= QN || tf >= QN))
            range_err <= 1'b1;
    end

    // p0: optional operand delay line that pads the pipe out to LAT
    logic         x_vld, x_mode;
    logic [N-1:0] x_an, x_bn, x_tf;

    generate
        if (PRE == 0) begin : g_nopre
            assign x_vld  = in_valid;
            assign x_mode = mode;
            assign x_an   = an_r;
            assign x_bn   = bn_r;
            assign x_tf   = tf_r;
        end else begin : g_pre
            logic         vld_p0  [PRE];
            logic         mode_p0 [PRE];
            logic [N-1:0] an_p0   [PRE];
            logic [N-1:0] bn_p0   [PRE];
            logic [N-1:0] tf_p0   [PRE];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PRE; i++) vld_p0[i] <= 1'b0;
                end else if (en) begin
                    vld_p0[0] <= in_valid;
                    for (int i = 1; i < PRE; i++) vld_p0[i] <= vld_p0[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    mode_p0[0] <= mode;
                    an_p0[0]   <= an_r;
                    bn_p0[0]   <= bn_r;
                    tf_p0[0]   <= tf_r;
                    for (int i = 1; i < PRE; i++) begin
                        mode_p0[i] <= mode_p0[i-1];
                        an_p0[i]   <= an_p0[i-1];
                        bn_p0[i]   <= bn_p0[i-1];
                        tf_p0[i]   <= tf_p0[i-1];
                    end
                end
            end

            assign x_vld  = vld_p0[PRE-1];
            assign x_mode = mode_p0[PRE-1];
            assign x_an   = an_p0[PRE-1];
            assign x_bn   = bn_p0[PRE-1];
            assign x_tf   = tf_p0[PRE-1];
        end
    endgenerate

    // p1: sum/difference and the single modular product (tf*bn for CT, tf*d for GS)
    logic [N-1:0] s_c, d_c, mulx_c, m_c;
    logic         vld_p1, mode_p1;
    logic [N-1:0] u_p1, m_p1;

    always_comb begin
        s_c    = addmod(x_an, x_bn);
        d_c    = submod(x_an, x_bn);
        mulx_c = x_mode ? d_c : x_bn;
        m_c    = mulmod(mulx_c, x_tf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (en)
            vld_p1 <= x_vld;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mode_p1 <= x_mode;
            u_p1    <= x_mode ? s_c : x_an;
            m_p1    <= m_c;
        end
    end

    // p2: CT add/sub or GS halving, registered onto the outputs
    logic [N-1:0] a_c, b_c;
    logic         vld_p2;

    always_comb begin
        if (!mode_p1) begin
            a_c = addmod(u_p1, m_p1);
            b_c = submod(u_p1, m_p1);
        end else begin
            a_c = SCALE ? half(u_p1) : u_p1;
            b_c = SCALE ? half(m_p1) : m_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            a      <= '0;
            b      <= '0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            a      <= a_c;
            b      <= b_c;
        end
    end

    assign out_valid = vld_p2;

endmodule

// File: doc/radix_2_butterfly_pipe.md
Name: radix_2_butterfly_pipe

Overview:
Pipelined, parametrised radix-2 butterfly PE. A mode input selects NTT (Cooley-Tukey) or INTT (Gentleman-Sande with 1/2 scaling) per transaction. It is fully reduced mod Q, has a fixed latency, and uses valid/ready handshakes on both sides. It sits between the coefficient-memory read port and the write-back path of the NTT/INTT stage controller, and replaces the combinational INTT PE.

Parameters:
N, 17, coefficient/twiddle width in bits; Q < 2^N
Q, 65537, modulus; odd prime
TWOINV, 32769, (Q+1)/2, the inverse of 2 mod Q
LAT, 3, pipeline latency in cycles; legal values 2..4

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  PE can accept an input this cycle
mode  in  1  0 = NTT (CT), 1 = INTT (GS); sampled with the transaction
an  in  N  first operand, unsigned, 0..Q-1
bn  in  N  second operand, unsigned, 0..Q-1
tf  in  N  twiddle factor, unsigned, 0..Q-1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
a  out  N  first result, 0..Q-1
b  out  N  second result, 0..Q-1
range_err  out  1  sticky flag: an accepted operand was >= Q

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: out_valid=0, a=0, b=0, range_err=0, all stage valids=0. in_ready=1 once rst_n is high.
- Reset asserted mid-operation: in-flight transactions are discarded, with no partial output.
- Accept and deliver: an input is accepted when in_valid && in_ready. A result is delivered when out_valid && out_ready.
- Stalling: in_ready = !out_valid || out_ready. A stall freezes the whole pipeline; there are no bubbles-collapse requirements.
- Output hold: while out_valid=1 and out_ready=0, a and b hold steady.
- Latency: with no stalls, a result appears exactly LAT cycles after acceptance. Results keep order; mode travels with its data. Throughput is 1 per cycle when out_ready=1.
- Back-to-back: throughput is sustained across mode changes, with no drain needed.
- NTT arithmetic (mode=0): t = tf*bn mod Q; a = (an + t) mod Q; b = (an - t) mod Q.
- INTT arithmetic (mode=1): s = (an + bn) mod Q; d = (an - bn) mod Q; a = s*TWOINV mod Q; b = d*tf*TWOINV mod Q.
- Width rules: subtraction is done as an + Q - x. Products are held in 2N bits before reduction. Every intermediate register is < Q, and outputs are always in 0..Q-1.
- Halving: multiply by TWOINV, or equivalently (x even ? x/2 : (x+Q)/2). Results must be bit-identical.
- Range check: any accepted an, bn or tf >= Q sets range_err. It stays set until rst_n. The transaction still proceeds, with the out-of-range operand reduced mod Q first.
- Simultaneous accept and deliver in the same cycle is legal. Occupancy is then unchanged.
- Idle: in_valid=0 inserts a bubble. out_valid deasserts for the corresponding cycle.

Optional Feature:
Macro: BFLY_INTT_SCALE_EN
- Defined: INTT mode applies the TWOINV scaling to both outputs, as specified above.
- Undefined: INTT outputs are unscaled (a = s, b = d*tf mod Q). The scaling by N^-1 is then done once by the post-INTT scaler. Latency stays LAT, and NTT mode is unchanged.

Test Plan:
- NTT, Q=65537: an=5, bn=3, tf=2 -> a=11, b=65536, out_valid exactly 3 cycles after accept.
- INTT with scale enabled: an=5, bn=3, tf=2 -> a=4, b=2. Boundary case an=0, bn=65536, tf=65536 -> a=32768, b=32768.
- Backpressure: stream 8 random transactions with mixed mode while out_ready toggles 1,0,0,1 repeating -> all 8 results are in order, match the golden model, a/b are stable while stalled, and in_ready=0 only when out_valid && !out_ready.
- Range error: accept bn=65537 in NTT mode with an=0, tf=1 -> range_err=1 and stays high. Result is a=0, b=0 (bn reduces to 0).
- Reset mid-stream: assert rst_n=0 asynchronously with 3 transactions in flight -> out_valid=0, a=b=0 immediately. No stale result appears after release.
- Random sweep: 10k transactions with random mode, operands and stalls -> scoreboard matches for N=17/Q=65537 and for N=14/Q=12289/TWOINV=6145.
